mem_stage_lsu: RTL
==================

// Module: mem_stage_lsu
// PURPOSE
//  MEM-stage load/store unit; consumer end of the EX/MEM pipeline register.
//  Turns the EX/MEM access (address, store data, MemWrite, DMType, WDSel) into a
//  req/ack data-memory bus transaction: byte lanes, store-data alignment, load
//  extension. Stalls the pipeline until the access completes; flags misalignment and bus timeout.
// PARAMETERS
//  ADDR_W   32  byte-address width on dmem_addr
//  TIMEOUT  16  max cycles in BUSY before bus_err; 0 = disabled
// PORTS
//  clk          in   1   clock, rising edge
//  rst          in   1   reset, asynchronous, active-low
//  alures_in    in   32  effective byte address (EX/MEM alures)
//  rs2_data_in  in   32  store data (EX/MEM rs2_data)
//  MemWrite_in  in   1   store request
//  DMType_in    in   3   access size/sign (pkg DM_*)
//  WDSel_in     in   3   WDSEL_FROM_MEM marks a load
//  dmem_req     out  1   bus request, held until dmem_ack
//  dmem_we      out  1   1=write, 0=read
//  dmem_addr    out  ADDR_W word-aligned address ([1:0]=0)
//  dmem_be      out  4   byte enables
//  dmem_wdata   out  32  lane-shifted store data
//  dmem_ack     in   1   bus completion, 1-cycle pulse
//  dmem_rdata   in   32  read word, valid with dmem_ack
//  mem_stall    out  1   hold IF..EX/MEM registers (combinational)
//  load_data    out  32  extended load result for MEM/WB
//  load_valid   out  1   1-cycle pulse, load_data valid
//  misalign_err out  1   1-cycle pulse, access dropped
//  bus_err      out  1   1-cycle pulse, timeout abort
// BEHAVIOUR
//  - access = MemWrite_in | (WDSel_in==WDSEL_FROM_MEM); MemWrite has priority if both.
//  - Reset: state=IDLE; dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, load_data,
//    load_valid, misalign_err, bus_err, timeout counter all 0. Mid-transaction reset
//    drops dmem_req immediately; a late ack is ignored.
//  - FSM IDLE->BUSY->DONE->IDLE.
//    IDLE: access & aligned -> latch addr/be/wdata/we, dmem_req<=1, ->BUSY.
//      access & misaligned (word: a[1:0]!=0; half: a[0]!=0) -> misalign_err<=1,
//      no request, stay IDLE. dmem_ack in IDLE ignored.
//    BUSY: req/we/addr/be/wdata stable until ack. On ack: req<=0; load -> load_data
//      <= extended rdata; ->DONE. cnt reaches TIMEOUT w/o ack: req<=0, bus_err<=1, ->DONE.
//    DONE: load_valid=1 iff load completed with ack; ->IDLE.
//  - mem_stall = (IDLE & access & aligned) | BUSY. Low in DONE: EX/MEM advances at
//    the DONE edge, so each access issues exactly once. Access latency: 3 cycles with
//    0-wait ack (IDLE, BUSY, DONE).
//  - Lanes: byte be=1<<a[1:0], wdata=rs2[7:0] replicated x4; half be=a[1]?1100:0011,
//    wdata={2{rs2[15:0]}}; word be=1111, wdata=rs2. Loads: be per size, we=0.
//  - Extension: select lane by a[1:0]; DM_BYTE/DM_HALF sign-ext; *_U zero-ext; word as-is.
// STRUCTURE
//  - Package mem_pkg: DM_WORD=0, DM_HALF=1, DM_HALF_U=2, DM_BYTE=3, DM_BYTE_U=4;
//    WDSEL_FROM_MEM=3'b001; FSM state enum.
//  - Sub-module lsu_align (combinational): be/wdata generation, load extraction and
//    extension, misalign detect; FSM, counter, registers stay in mem_stage_lsu.
//  - Undefined DMType codes: treated as DM_WORD.
// TESTING
//  1 sw a=0x100 d=0xDEADBEEF, ack 2 cycles after req -> be=1111, wdata=0xDEADBEEF, stall 3 cycles.
//  2 sb a=0x103 d=0x000000A5 -> addr=0x100, be=1000, wdata=0xA5A5A5A5.
//  3 lb a=0x102, rdata=0x00800000 -> load_data=0xFFFFFF80; lbu -> 0x00000080, load_valid 1 pulse.
//  4 lh a=0x101 -> misalign_err pulse, dmem_req never asserted, mem_stall 0.
//  5 lw, no ack, TIMEOUT=16 -> req drops after 16 BUSY cycles, bus_err pulse, load_valid 0.
//  6 rst low during BUSY -> all outputs 0 same cycle; ack after release ignored, no load_valid.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared encodings for the MEM-stage load/store unit: DMType codes, WDSel load
// marker, access-size decode helpers and the transaction FSM state type.
package mem_pkg;

  localparam logic [2:0] DM_WORD   = 3'd0;
  localparam logic [2:0] DM_HALF   = 3'd1;
  localparam logic [2:0] DM_HALF_U = 3'd2;
  localparam logic [2:0] DM_BYTE   = 3'd3;
  localparam logic [2:0] DM_BYTE_U = 3'd4;

  localparam logic [2:0] WDSEL_FROM_MEM = 3'b001;

  typedef enum logic [1:0] {
    SZ_BYTE,
    SZ_HALF,
    SZ_WORD
  } acc_size_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_BUSY,
    ST_DONE
  } lsu_state_t;

  // Unknown DMType codes fall through to a full-word access.
  function automatic acc_size_t dm_size(input logic [2:0] dm_type);
    case (dm_type)
      DM_BYTE, DM_BYTE_U: return SZ_BYTE;
      DM_HALF, DM_HALF_U: return SZ_HALF;
      default:            return SZ_WORD;
    endcase
  endfunction

  function automatic logic dm_signed(input logic [2:0] dm_type);
    return (dm_type == DM_BYTE) || (dm_type == DM_HALF);
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: byte enables, store-data replication, misalignment
// detection for the issuing access, and lane extraction/extension of load data.
module lsu_align
  import mem_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  dm_type,
  input  logic [31:0] store_data,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic        misaligned,
  input  logic [1:0]  ld_offset,
  input  logic [2:0]  ld_type,
  input  logic [31:0] rdata,
  output logic [31:0] load_ext
);

  logic [31:0] shifted;
  logic        sext;

  // NOTE: every output gets a default before the case so no path leaves a latch.
  always_comb begin
    be         = 4'b1111;
    wdata      = store_data;
    misaligned = |addr_lo;
    case (dm_size(dm_type))
      SZ_BYTE: begin
        be         = 4'b0001 << addr_lo;
        wdata      = {4{store_data[7:0]}};
        misaligned = 1'b0;
      end
      SZ_HALF: begin
        be         = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata      = {2{store_data[15:0]}};
        misaligned = addr_lo[0];
      end
      default: ;
    endcase
  end

  assign shifted = rdata >> {ld_offset, 3'b000};
  assign sext    = dm_signed(ld_type);

  always_comb begin
    load_ext = rdata;
    case (dm_size(ld_type))
      SZ_BYTE: load_ext = {{24{sext & shifted[7]}}, shifted[7:0]};
      SZ_HALF: load_ext = {{16{sext & shifted[15]}}, shifted[15:0]};
      default: ;
    endcase
  end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM-stage load/store unit: converts the EX/MEM access into one req/ack bus
// transaction, stalls the pipeline while it is outstanding, and reports errors.
module mem_stage_lsu
  import mem_pkg::*;
#(
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       alures_in,
  input  logic [31:0]       rs2_data_in,
  input  logic              MemWrite_in,
  input  logic [2:0]        DMType_in,
  input  logic [2:0]        WDSel_in,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [3:0]        dmem_be,
  output logic [31:0]       dmem_wdata,
  input  logic              dmem_ack,
  input  logic [31:0]       dmem_rdata,
  output logic              mem_stall,
  output logic [31:0]       load_data,
  output logic              load_valid,
  output logic              misalign_err,
  output logic              bus_err
);

  localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  lsu_state_t state, state_nxt;

  logic             access, misaligned;
  logic [3:0]       be_new;
  logic [31:0]      wdata_new, load_ext;
  logic             issue, flag_misalign, complete, abort, timeout_hit;
  logic             ld_pending;
  logic [2:0]       ld_type;
  logic [1:0]       ld_offset;
  logic [CNT_W-1:0] cnt;

  assign access = MemWrite_in | (WDSel_in == WDSEL_FROM_MEM);

  lsu_align u_align (
    .addr_lo    (alures_in[1:0]),
    .dm_type    (DMType_in),
    .store_data (rs2_data_in),
    .be         (be_new),
    .wdata      (wdata_new),
    .misaligned (misaligned),
    .ld_offset  (ld_offset),
    .ld_type    (ld_type),
    .rdata      (dmem_rdata),
    .load_ext   (load_ext)
  );

  assign timeout_hit = (TIMEOUT != 0) && (cnt == CNT_W'(TIMEOUT - 1));

  always_comb begin
    state_nxt     = state;
    issue         = 1'b0;
    flag_misalign = 1'b0;
    complete      = 1'b0;
    abort         = 1'b0;
    case (state)
      ST_IDLE: begin
        if (access) begin
          if (misaligned) begin
            flag_misalign = 1'b1;
          end else begin
            issue     = 1'b1;
            state_nxt = ST_BUSY;
          end
        end
      end
      ST_BUSY: begin
        if (dmem_ack) begin
          complete  = 1'b1;
          state_nxt = ST_DONE;
        end else if (timeout_hit) begin
          abort     = 1'b1;
          state_nxt = ST_DONE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Stall is forced low while reset is held so the pipeline is released at once.
  assign mem_stall = rst & (issue | (state == ST_BUSY));

  // NOTE: state and all datapath registers use non-blocking assignments so every
  // flop samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  // NOTE: only these control/datapath flops need reset; there is no memory array here.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dmem_req     <= 1'b0;
      dmem_we      <= 1'b0;
      dmem_addr    <= '0;
      dmem_be      <= '0;
      dmem_wdata   <= '0;
      load_data    <= '0;
      load_valid   <= 1'b0;
      misalign_err <= 1'b0;
      bus_err      <= 1'b0;
      cnt          <= '0;
      ld_pending   <= 1'b0;
      ld_type      <= DM_WORD;
      ld_offset    <= '0;
    end else begin
      misalign_err <= flag_misalign;
      bus_err      <= abort;
      load_valid   <= complete & ld_pending;
      if (issue) begin
        dmem_req   <= 1'b1;
        dmem_we    <= MemWrite_in;
        dmem_addr  <= {alures_in[ADDR_W-1:2], 2'b00};
        dmem_be    <= be_new;
        dmem_wdata <= wdata_new;
        ld_pending <= ~MemWrite_in;
        ld_type    <= DMType_in;
        ld_offset  <= alures_in[1:0];
        cnt        <= '0;
      end else if (state == ST_BUSY) begin
        cnt <= cnt + 1'b1;
      end
      if (complete || abort) dmem_req <= 1'b0;
      if (complete && ld_pending) load_data <= load_ext;
    end
  end

endmodule
